adder_rr_sched: RTL and testbench

Round-robin scheduler that shares one combinational four-operand `adder` (WIDTH-bit inputs, WIDTH+2-bit sum) among NREQ requesters. Each requester presents four operands with a valid/ready handshake. The block grants one requester per cycle, registers the sum together with the requester index, and returns it on a single valid/ready response port. It sits between the operand producers and the shared adder instance, which it owns internally.

---
 rtl/adder_rr_sched.sv | 108 ++++++++++
 tb/tb_adder_rr_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one four-operand adder among NREQ requesters.
// One registered response slot; drain and refill may happen in the same cycle.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH+1:0] sum
);
  assign sum = {2'b00, a} + {2'b00, b}
             + {2'b00, c} + {2'b00, d};
endmodule

module adder_rr_sched #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*WIDTH-1:0] req_c,
  input  logic [NREQ*WIDTH-1:0] req_d,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH+1:0]      rsp_sum
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     scan;
  logic             found;
  logic             slot_free;
  logic             grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_c;
  logic [WIDTH-1:0] op_d;
  logic [WIDTH+1:0] sum;
  logic [IDW-1:0]   ptr_nxt;

  assign slot_free = !rsp_valid || rsp_ready;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) begin
        scan = scan - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[scan[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
  end

  assign grant = rst_n && slot_free && found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign op_a = req_a[gnt_idx*WIDTH +: WIDTH];
  assign op_b = req_b[gnt_idx*WIDTH +: WIDTH];
  assign op_c = req_c[gnt_idx*WIDTH +: WIDTH];
  assign op_d = req_d[gnt_idx*WIDTH +: WIDTH];

  adder #(.WIDTH(WIDTH)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .c   (op_c),
    .d   (op_d),
    .sum (sum)
  );

  assign ptr_nxt = (gnt_idx == IDW'(NREQ-1)) ? '0
                 : gnt_idx + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      ptr       <= '0;
    end else if (slot_free) begin
      rsp_valid <= grant;
      if (grant) begin
        rsp_id  <= gnt_idx;
        rsp_sum <= sum;
        ptr     <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: vector table plus
// hand-written reset and single-request sequences.
module tb_adder_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a, req_b, req_c, req_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_sum;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a, b, c, d;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [5:0]  exp_sum;
    logic [1:0]  exp_ptr;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  adder_rr_sched #(.WIDTH(4), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v,
                       input logic [15:0] a, b, c, d,
                       input logic rr);
    req_valid = v;
    req_a = a; req_b = b; req_c = c; req_d = d;
    rsp_ready = rr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(logic [3:0] v, logic [15:0] a, b, c, d,
                              logic rr, logic [3:0] er, logic ev,
                              logic [1:0] ei, logic [5:0] es,
                              logic [1:0] ep);
    vec_t t;
    t.valid = v; t.a = a; t.b = b; t.c = c; t.d = d;
    t.rr = rr; t.exp_ready = er; t.exp_valid = ev;
    t.exp_id = ei; t.exp_sum = es; t.exp_ptr = ep;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    #1;

    // reset state, with requests asserted while in reset
    do_reset();
    rst_n = 1'b0;
    drive(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1'b1);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    step();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_sum", 32'(rsp_sum), 32'd0);
    check("rst_ptr", 32'(dut.ptr), 32'd0);

    // single request from requester 2, all operands 15
    do_reset();
    drive(4'b0100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    step();
    drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_sum", 32'(rsp_sum), 32'd60);
    check("single_id", 32'(rsp_id), 32'd2);

    // table: rotation, backpressure, skip, zero/idle, late valid
    do_reset();
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1, 4'b0001, 1, 0, 0, 1));
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1, 4'b0010, 1, 1, 4, 2));
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1, 4'b0100, 1, 2, 8, 3));
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1, 4'b1000, 1, 3, 12, 0));
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1, 4'b0001, 1, 0, 0, 1));
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 0, 4'b0000, 1, 0, 0, 1));
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 0, 4'b0000, 1, 0, 0, 1));
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 0, 4'b0000, 1, 0, 0, 1));
    tbl.push_back(mk(4'hF, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1, 4'b0010, 1, 1, 4, 2));
    tbl.push_back(mk(4'hA, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1, 4'b1000, 1, 3, 12, 0));
    tbl.push_back(mk(4'h2, 16'h3210, 16'h3210, 16'h3210, 16'h3210, 1, 4'b0010, 1, 1, 4, 2));
    tbl.push_back(mk(4'h1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 4'b0001, 1, 0, 0, 1));
    tbl.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'h4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 4'b0100, 1, 2, 60, 3));
    tbl.push_back(mk(4'h8, 16'hF000, 16'h1000, 16'h7000, 16'h0000, 1, 4'b1000, 1, 3, 23, 0));
    tbl.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 3, 23, 0));
    tbl.push_back(mk(4'h1, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 0, 4'b0000, 1, 3, 23, 0));
    tbl.push_back(mk(4'h1, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 1, 4'b0001, 1, 0, 11, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].rr);
      #1;
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      step();
      check($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_valid));
      check($sformatf("v%0d_id", i), 32'(rsp_id), 32'(tbl[i].exp_id));
      check($sformatf("v%0d_sum", i), 32'(rsp_sum), 32'(tbl[i].exp_sum));
      check($sformatf("v%0d_ptr", i), 32'(dut.ptr), 32'(tbl[i].exp_ptr));
    end

    // reset mid-operation with requester 3 still waiting
    do_reset();
    drive(4'b1001, 16'h2003, 16'h1004, 16'h0000, 16'h0000, 1'b0);
    #1;
    check("mid_ready0", 32'(req_ready), 32'h1);
    step();
    check("mid_pend", 32'(rsp_valid), 32'd1);
    check("mid_pend_sum", 32'(rsp_sum), 32'd7);
    req_valid = 4'b1000;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    check("mid_valid", 32'(rsp_valid), 32'd0);
    check("mid_id", 32'(rsp_id), 32'd0);
    check("mid_sum", 32'(rsp_sum), 32'd0);
    check("mid_ptr", 32'(dut.ptr), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("mid_ready3", 32'(req_ready), 32'h8);
    step();
    drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    check("mid_id3", 32'(rsp_id), 32'd3);
    check("mid_sum3", 32'(rsp_sum), 32'd3);
    check("mid_ptr3", 32'(dut.ptr), 32'd0);
    step();
    check("mid_idle", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
